uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Owns the register port of the UART master IP: `I_TX_EN`/`I_WADDR`/`I_WDATA` and `I_RX_EN`/`I_RADDR`/`O_RDATA`.
- After reset, it programs the 16550-style UART for 8N1 at a fixed divisor and enables the FIFOs.
- It then shares the transmitter between NUM_REQ byte-stream requesters using round-robin arbitration.
- Before each THR write it polls LSR.THRE, so no byte is ever dropped. Sits between message generators (hello-world style producers) and the UART IP.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DIVISOR, 16'd15, baud divisor written to DLL/DLM (27 MHz / 16 / 115200).
- RD_LAT, 2, cycles from the `i_rx_en` pulse to valid `rdata` (1..4).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  NUM_REQ  per-requester byte valid
- req_data  in  NUM_REQ*8  packed bytes; requester k uses bits [8k+7:8k]
- req_ready  out  NUM_REQ  one-hot, 1-cycle accept pulse
- i_tx_en  out  1  UART register write strobe
- waddr  out  3  UART write address
- wdata  out  8  UART write data
- i_rx_en  out  1  UART register read strobe
- raddr  out  3  UART read address
- rdata  in  8  UART read data
- init_done  out  1  high once configuration is complete
- grant_id  out  $clog2(NUM_REQ)  index of the requester currently being served

Behaviour:
- Reset state: all outputs 0; FSM in INIT_LCR1; round-robin pointer last = NUM_REQ-1. Reset mid-operation aborts everything, including a pending write, and reruns init.
- Register addresses: 0 = THR/DLL, 1 = DLM, 2 = FCR, 3 = LCR, 5 = LSR. Read address 0 (RBR) is never issued, because reading it pops the RX FIFO.
- Every register write is a single-cycle `i_tx_en` pulse, with `waddr`/`wdata` valid in the same cycle. `wdata`/`waddr` hold their values afterwards. Consecutive writes are separated by at least 1 idle cycle.
- Init sequence (one write per state, one gap cycle between states):
  - INIT_LCR1: LCR = 8'h83 (DLAB set)
  - INIT_DLL: DLL = DIVISOR[7:0]
  - INIT_DLM: DLM = DIVISOR[15:8]
  - INIT_LCR2: LCR = 8'h03
  - INIT_FCR: FCR = 8'h07
  - Then `init_done` goes to 1 and stays 1 until reset. `req_ready` stays 0 throughout init.
- IDLE, when init_done = 1 and any `req_valid` is set:
  - Grant the first valid index after `last`, wrapping modulo NUM_REQ.
  - In the same cycle, pulse `req_ready[g]`, latch `req_data[g]` into a byte register, set `grant_id` = g and `last` = g, then go to POLL.
  - No valid requester: stay in IDLE.
- POLL: pulse `i_rx_en` for 1 cycle with `raddr` = 5, load a latency counter with RD_LAT, go to WAIT.
- WAIT: decrement the counter; when it reaches 0, sample `rdata` and go to CHECK.
- CHECK:
  - `rdata[5]` = 1: go to WRITE.
  - Otherwise: return to POLL after 1 gap cycle. There is no timeout; the block polls indefinitely.
- WRITE: `i_tx_en` = 1, `waddr` = 0, `wdata` = latched byte, then go to IDLE. The next grant can occur in the cycle after WRITE.
- Throughput with THRE already set: one byte per 4+RD_LAT cycles (grant, poll, RD_LAT wait, write).
- Simultaneous `req_valid` deassertion after `req_ready` has no effect; the byte is already latched.
- `req_valid` is sampled only in IDLE.
- `i_tx_en` and `i_rx_en` are never high in the same cycle.

Decomposition:
- Package `uart_regs_pkg`:
  - Register address localparams: UART_THR, UART_DLL, UART_DLM, UART_FCR, UART_LCR, UART_LSR.
  - Bit constants: LSR_THRE = 5, LCR_DLAB_8N1 = 8'h83, LCR_8N1 = 8'h03, FCR_EN_CLR = 8'h07.
  - FSM state enum `uart_arb_state_t`.
- Sub-module `rr_arbiter`: parameterised on NUM_REQ; inputs request mask and `last`; outputs a grant index and a `found` flag; purely combinational.

Test Plan:
- Init: release rst, hold `req_valid` = 0 -> writes occur in order (3,83), (0,0F), (1,00), (3,03), (2,07), separated by ≥1 idle cycle; then `init_done` = 1; `req_ready` is never asserted during init.
- Single byte: requester 1 presents 8'h48 with the model returning LSR = 8'h60 -> `req_ready` = 4'b0010, `grant_id` = 1, one LSR read (`raddr` = 5), then write (0,48) RD_LAT+2 cycles after the read pulse.
- Round-robin: all 4 requesters valid continuously with bytes 8'hA0..A3 -> grant order 0,1,2,3,0 and THR writes A0,A1,A2,A3,A0.
- THRE backpressure: the model returns LSR = 8'h00 for 3 polls, then 8'h20 -> exactly 4 `i_rx_en` pulses precede one THR write; no second grant occurs meanwhile.
- Reset mid-operation: assert rst during WAIT -> the next cycle has all outputs 0, no THR write occurs, and the full init sequence repeats.
- Strobe exclusivity: random `req_valid` and LSR values over 10k cycles -> `i_tx_en & i_rx_en` is never 1, `raddr` is never 0 on a read, and `req_ready` is always one-hot or zero.

Source files
------------

// File: rtl/uart_regs_pkg.sv
// rtl/uart_regs_pkg.sv - 16550 register map, control constants and arbiter FSM states
package uart_regs_pkg;

    localparam logic [2:0] UART_THR = 3'd0;
    localparam logic [2:0] UART_DLL = 3'd0;
    localparam logic [2:0] UART_DLM = 3'd1;
    localparam logic [2:0] UART_FCR = 3'd2;
    localparam logic [2:0] UART_LCR = 3'd3;
    localparam logic [2:0] UART_LSR = 3'd5;

    localparam int         LSR_THRE     = 5;
    localparam logic [7:0] LCR_DLAB_8N1 = 8'h83;
    localparam logic [7:0] LCR_8N1      = 8'h03;
    localparam logic [7:0] FCR_EN_CLR   = 8'h07;

    typedef enum logic [3:0] {
        INIT_LCR1 = 4'd0,
        INIT_DLL  = 4'd1,
        INIT_DLM  = 4'd2,
        INIT_LCR2 = 4'd3,
        INIT_FCR  = 4'd4,
        IDLE      = 4'd5,
        POLL      = 4'd6,
        WAIT      = 4'd7,
        CHECK     = 4'd8,
        RETRY     = 4'd9,
        WRITE     = 4'd10
    } uart_arb_state_t;

    // Index reached by stepping `off` places past `last` around a ring of n entries.
    function automatic int rr_index(input int last, input int off, input int n);
        return (last + off) % n;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first set request after `last`
module rr_arbiter
    import uart_regs_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last,
    output logic [$clog2(NUM_REQ)-1:0] grant,
    output logic                       found
);

    localparam int IW = $clog2(NUM_REQ);

    // Walk from the farthest offset to the nearest so the nearest valid index wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            if (req[IW'(rr_index(int'(last), off, NUM_REQ))]) begin
                grant = IW'(rr_index(int'(last), off, NUM_REQ));
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - configures the UART for 8N1, then feeds THR from
// round-robin requesters, polling LSR.THRE before every byte
module uart_tx_arbiter
    import uart_regs_pkg::*;
#(
    parameter int          NUM_REQ = 4,
    parameter logic [15:0] DIVISOR = 16'd15,
    parameter int          RD_LAT  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*8-1:0]       req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       i_tx_en,
    output logic [2:0]                 waddr,
    output logic [7:0]                 wdata,
    output logic                       i_rx_en,
    output logic [2:0]                 raddr,
    input  logic [7:0]                 rdata,
    output logic                       init_done,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(RD_LAT + 1);

    uart_arb_state_t state_q, state_d;
    logic            gap_q, gap_d;
    logic            init_done_q, init_done_d;
    logic [IW-1:0]   last_q, last_d;
    logic [IW-1:0]   grant_id_q, grant_id_d;
    logic [7:0]      byte_q, byte_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            thre_q, thre_d;
    logic [2:0]      waddr_q, waddr_d;
    logic [7:0]      wdata_q, wdata_d;
    logic [2:0]      raddr_q, raddr_d;
    logic            tx_en, rx_en;
    logic [NUM_REQ-1:0] ready;

    logic [IW-1:0]   rr_grant;
    logic            rr_found;
    logic            unused_rdata;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req   (req_valid),
        .last  (last_q),
        .grant (rr_grant),
        .found (rr_found)
    );

    // Only THRE matters; the rest of LSR is read but ignored.
    assign unused_rdata = ^rdata;

    always_comb begin
        state_d     = state_q;
        gap_d       = gap_q;
        init_done_d = init_done_q;
        last_d      = last_q;
        grant_id_d  = grant_id_q;
        byte_d      = byte_q;
        cnt_d       = cnt_q;
        thre_d      = thre_q;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        raddr_d     = raddr_q;
        tx_en       = 1'b0;
        rx_en       = 1'b0;
        ready       = '0;

        unique case (state_q)
            // Each init state spends one idle cycle (gap_q) and then one write cycle.
            INIT_LCR1, INIT_DLL, INIT_DLM, INIT_LCR2, INIT_FCR: begin
                if (gap_q) begin
                    gap_d = 1'b0;
                end else begin
                    tx_en = 1'b1;
                    gap_d = 1'b1;
                    unique case (state_q)
                        INIT_LCR1: begin
                            waddr_d = UART_LCR;
                            wdata_d = LCR_DLAB_8N1;
                            state_d = INIT_DLL;
                        end
                        INIT_DLL: begin
                            waddr_d = UART_DLL;
                            wdata_d = DIVISOR[7:0];
                            state_d = INIT_DLM;
                        end
                        INIT_DLM: begin
                            waddr_d = UART_DLM;
                            wdata_d = DIVISOR[15:8];
                            state_d = INIT_LCR2;
                        end
                        INIT_LCR2: begin
                            waddr_d = UART_LCR;
                            wdata_d = LCR_8N1;
                            state_d = INIT_FCR;
                        end
                        default: begin
                            waddr_d     = UART_FCR;
                            wdata_d     = FCR_EN_CLR;
                            state_d     = IDLE;
                            init_done_d = 1'b1;
                        end
                    endcase
                end
            end
            IDLE: begin
                if (init_done_q && rr_found) begin
                    for (int k = 0; k < NUM_REQ; k++) begin
                        if (rr_grant == IW'(k)) begin
                            ready[k] = 1'b1;
                            byte_d   = req_data[k*8 +: 8];
                        end
                    end
                    grant_id_d = rr_grant;
                    last_d     = rr_grant;
                    state_d    = POLL;
                end
            end
            POLL: begin
                rx_en   = 1'b1;
                raddr_d = UART_LSR;
                cnt_d   = CW'(RD_LAT);
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    thre_d  = rdata[LSR_THRE];
                    state_d = CHECK;
                end
            end
            CHECK: begin
                state_d = thre_q ? WRITE : RETRY;
            end
            RETRY: begin
                state_d = POLL;
            end
            WRITE: begin
                tx_en   = 1'b1;
                waddr_d = UART_THR;
                wdata_d = byte_q;
                state_d = IDLE;
            end
            default: begin
                state_d = INIT_LCR1;
                gap_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= INIT_LCR1;
            gap_q       <= 1'b1;
            init_done_q <= 1'b0;
            last_q      <= IW'(NUM_REQ - 1);
            grant_id_q  <= '0;
            byte_q      <= '0;
            cnt_q       <= '0;
            thre_q      <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            raddr_q     <= '0;
        end else begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            init_done_q <= init_done_d;
            last_q      <= last_d;
            grant_id_q  <= grant_id_d;
            byte_q      <= byte_d;
            cnt_q       <= cnt_d;
            thre_q      <= thre_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            raddr_q     <= raddr_d;
        end
    end

    // Strobes decode the current state so address/data are valid in the strobe cycle.
    assign i_tx_en   = tx_en;
    assign i_rx_en   = rx_en;
    assign waddr     = waddr_d;
    assign wdata     = wdata_d;
    assign raddr     = raddr_d;
    assign req_ready = ready;
    assign init_done = init_done_q;
    assign grant_id  = grant_id_q;

endmodule
